// File: rtl/hb_window_monitor.sv
// Heartbeat window monitor: synchronises and deglitches a DSP square-wave heartbeat, measures
// half-periods against a window and latches a fault cause. Define HB_AUTORECOVER_EN to let FAULT self-clear.
module hb_window_monitor #(
    parameter int CNT_W      = 20,
    parameter int MIN_HALF   = 1000,
    parameter int MAX_HALF   = 50000,
    parameter int LOCK_EDGES = 4,
    parameter int MAX_BAD    = 2,
    parameter int FILT_LEN   = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iSquareWave,
    input  logic             iClr,
    output logic             oBeat,
    output logic [CNT_W-1:0] oPeriod,
    output logic             oLocked,
    output logic             oFault,
    output logic [1:0]       oFaultCode
);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int GW = $clog2(LOCK_EDGES + 1);
    localparam int BW = $clog2(MAX_BAD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HALF);
    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_STUCK = 2'b01;
    localparam logic [1:0] CODE_FAST  = 2'b10;
    localparam logic [1:0] CODE_SLOW  = 2'b11;

    typedef enum logic [1:0] {ARM, LOCK, RUN, FAULT} state_t;

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             beat_q, edge_w;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, period_q, period_d, meas_w;
    state_t           state_q, state_d;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic [BW-1:0]    bad_q, bad_d, bad_inc;
    logic [1:0]       code_q, code_d, fault_code_q;
    logic             locked_q, fault_q;
    logic             fast_w, slow_w, good_w, timeout_w;

    // The filtered level only follows the synchroniser after FILT_LEN unbroken mismatch cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        edge_w = 1'b0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
                edge_w = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // meas doubles as the saturating increment of the half-period counter.
    always_comb begin
        meas_w    = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 1'b1;
        hcnt_d    = edge_w ? '0 : meas_w;
        period_d  = edge_w ? meas_w : period_q;
        fast_w    = meas_w < MIN_C;
        slow_w    = meas_w > MAX_C;
        good_w    = !fast_w && !slow_w;
        timeout_w = !edge_w && slow_w;
        good_inc  = good_q + 1'b1;
        bad_inc   = bad_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        code_d  = code_q;
        case (state_q)
            ARM: begin
                if (edge_w) begin
                    state_d = LOCK;
                    good_d  = '0;
                end
            end
            LOCK: begin
                if (edge_w) begin
                    if (!good_w) begin
                        good_d = '0;
                    end else if (good_inc == GW'(LOCK_EDGES)) begin
                        state_d = RUN;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end else if (timeout_w) begin
                    state_d = ARM;
                    good_d  = '0;
                end
            end
            RUN: begin
                if (edge_w) begin
                    if (good_w) begin
                        bad_d = '0;
                    end else if (bad_inc == BW'(MAX_BAD)) begin
                        state_d = FAULT;
                        code_d  = fast_w ? CODE_FAST : CODE_SLOW;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_inc;
                    end
                end else if (timeout_w) begin
                    state_d = FAULT;
                    code_d  = CODE_STUCK;
                    good_d  = '0;
                    bad_d   = '0;
                end
            end
            FAULT: begin
                if (iClr) begin
                    state_d = ARM;
                    code_d  = CODE_NONE;
                    good_d  = '0;
                    bad_d   = '0;
                end
`ifdef HB_AUTORECOVER_EN
                else if (edge_w) begin
                    if (!good_w) begin
                        good_d = '0;
                    end else if (good_inc == GW'(LOCK_EDGES)) begin
                        state_d = RUN;
                        code_d  = CODE_NONE;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
`endif
            end
            default: state_d = ARM;
        endcase
    end

    // Status outputs are registered from the state, so they trail the triggering cycle by one.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            filt_q       <= 1'b0;
            fcnt_q       <= '0;
            beat_q       <= 1'b0;
            hcnt_q       <= '0;
            period_q     <= '0;
            state_q      <= ARM;
            good_q       <= '0;
            bad_q        <= '0;
            code_q       <= CODE_NONE;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= CODE_NONE;
        end else begin
            sync1_q      <= iSquareWave;
            sync2_q      <= sync1_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            beat_q       <= edge_w;
            hcnt_q       <= hcnt_d;
            period_q     <= period_d;
            state_q      <= state_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            code_q       <= code_d;
            locked_q     <= (state_q == RUN);
            fault_q      <= (state_q == FAULT);
            fault_code_q <= code_q;
        end
    end

    assign oBeat      = beat_q;
    assign oPeriod    = period_q;
    assign oLocked    = locked_q;
    assign oFault     = fault_q;
    assign oFaultCode = fault_code_q;
endmodule
